// File: rtl/mmio_input_port.sv
// Purpose: memory-mapped switch/button input port with 2-flop sync, tick-sampled debounce and sticky press flags.
// Latency: loads return on the cycle after rd_en; stores take effect at the same clock edge; irq is one cycle behind its sources.
// Backpressure: none; one load and one store may be accepted every cycle, and rd_valid is a single-cycle pulse.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   sw_raw, btn_raw     asynchronous switch / push-button levels (button 1 = pressed)
//   rd_en, rd_addr      load strobe and register index
//   rd_data, rd_valid   registered load response, zero when rd_valid is low
//   wr_en, wr_addr,     store strobe, register index and data
//   wr_data
//   irq                 level flag, OR of press flags that are enabled
//
// Register map (index: contents):
//   0 SW_STATE   debounced switches, read-only
//   1 BTN_STATE  debounced buttons, read-only
//   2 BTN_EDGE   sticky press flags, write 1 to clear
//   3 IRQ_EN     per-button enable, read/write
//   4 INFO       {8'h01, 8'h00, NUM_BTN, NUM_SW}
//   5-7          read as zero

module mmio_input_port #(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               rd_en,
    input  logic [2:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [31:0]        wr_data,
    output logic               irq
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]       INFO_VAL  = {8'h01, 8'h00, 8'(NUM_BTN), 8'(NUM_SW)};

    localparam logic [2:0] IDX_SW_STATE  = 3'd0;
    localparam logic [2:0] IDX_BTN_STATE = 3'd1;
    localparam logic [2:0] IDX_BTN_EDGE  = 3'd2;
    localparam logic [2:0] IDX_IRQ_EN    = 3'd3;
    localparam logic [2:0] IDX_INFO      = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0]  sw_meta;
    logic [NUM_SW-1:0]  sw_sync;
    logic [NUM_BTN-1:0] btn_meta;
    logic [NUM_BTN-1:0] btn_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Sample tick: free-running divider, one pulse every DEBOUNCE_CYCLES
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit is accepted only when the synchronized level matches
    // the level captured at the previous tick, so any glitch shorter than
    // one tick period can never be seen at two consecutive ticks.
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0]  sw_samp;
    logic [NUM_SW-1:0]  sw_deb;
    logic [NUM_SW-1:0]  sw_agree;
    logic [NUM_BTN-1:0] btn_samp;
    logic [NUM_BTN-1:0] btn_deb;
    logic [NUM_BTN-1:0] btn_agree;

    assign sw_agree  = ~(sw_sync ^ sw_samp);
    assign btn_agree = ~(btn_sync ^ btn_samp);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_samp  <= '0;
            sw_deb   <= '0;
            btn_samp <= '0;
            btn_deb  <= '0;
        end else if (tick) begin
            sw_samp  <= sw_sync;
            sw_deb   <= (sw_sync & sw_agree) | (sw_deb & ~sw_agree);
            btn_samp <= btn_sync;
            btn_deb  <= (btn_sync & btn_agree) | (btn_deb & ~btn_agree);
        end
    end

    // ------------------------------------------------------------------
    // Press capture and sticky flags
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_deb_d;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_edge;
    logic [NUM_BTN-1:0] edge_clr;
    logic [NUM_BTN-1:0] irq_en;

    // Only the 0->1 transition of the debounced level counts; a held
    // button therefore produces one flag and a release produces none.
    assign btn_rise = btn_deb & ~btn_deb_d;
    assign edge_clr = (wr_en && (wr_addr == IDX_BTN_EDGE)) ? wr_data[NUM_BTN-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_deb_d <= '0;
            btn_edge  <= '0;
            irq_en    <= '0;
            irq       <= 1'b0;
        end else begin
            btn_deb_d <= btn_deb;
            // The rise term is ORed in after the clear so a press that lands
            // on the same edge as a write-1-to-clear is not lost.
            btn_edge  <= (btn_edge & ~edge_clr) | btn_rise;
            if (wr_en && (wr_addr == IDX_IRQ_EN)) begin
                irq_en <= wr_data[NUM_BTN-1:0];
            end
            irq       <= |(btn_edge & irq_en);
        end
    end

    // Store data above the widest writable field has no destination.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;

    // ------------------------------------------------------------------
    // Load port: mux uses pre-edge register values, so a load colliding
    // with a store or a press flag update returns the old contents.
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (rd_addr)
            IDX_SW_STATE:  rd_mux = 32'(sw_deb);
            IDX_BTN_STATE: rd_mux = 32'(btn_deb);
            IDX_BTN_EDGE:  rd_mux = 32'(btn_edge);
            IDX_IRQ_EN:    rd_mux = 32'(irq_en);
            IDX_INFO:      rd_mux = INFO_VAL;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_mux : '0;
        end
    end

endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
Memory-mapped input peripheral for the mini RISC core, the input-side counterpart of the LED display path. It synchronizes and debounces the board switches and push-buttons and captures sticky button-press events. The processor datapath reads these through a 1-cycle load port and clears them through a store port. It also raises a level interrupt/poll flag for enabled button events.

Parameters:
NUM_SW, 16, number of slide switches (1..32)
NUM_BTN, 4, number of push-buttons (1..32)
DEBOUNCE_CYCLES, 100000, sample-tick period in clk cycles (>=2; benches use 4)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
sw_raw  in  NUM_SW  asynchronous switch inputs
btn_raw  in  NUM_BTN  asynchronous button inputs, 1 = pressed
rd_en  in  1  load strobe from datapath
rd_addr  in  3  register index
rd_data  out  32  read data, zero-extended
rd_valid  out  1  rd_data valid this cycle
wr_en  in  1  store strobe
wr_addr  in  3  register index
wr_data  in  32  store data
irq  out  1  |(BTN_EDGE & IRQ_EN), registered

Behaviour:
- Reset (reset_n=0 at posedge clk): sync flops, samples, debounced state, BTN_EDGE, IRQ_EN and tick counter all clear to 0. rd_data=0, rd_valid=0, irq=0. Reset mid-operation discards any in-flight read; rd_valid is 0 in the following cycle.
- Synchronizer: 2-flop per bit on sw_raw and btn_raw, giving sync_* 2 cycles after the input changes.
- Tick: counter runs 0..DEBOUNCE_CYCLES-1 and wraps. tick=1 in the cycle where count==DEBOUNCE_CYCLES-1. The counter runs continuously out of reset.
- Debounce, per vector, on tick: samp <= sync. If sync==samp (bitwise), deb <= sync for those bits; other bits hold.
  - A level is accepted only after it has been present at two consecutive ticks.
  - Glitches shorter than DEBOUNCE_CYCLES never reach deb.
  - Worst-case acceptance latency is 2 + 2*DEBOUNCE_CYCLES cycles.
- Edge capture: btn_rise = deb_btn & ~deb_btn_d (deb_btn_d is deb_btn delayed 1 cycle). Each risen bit sets BTN_EDGE, which is sticky.
- Register map (index, read, write):
  - 0 SW_STATE: deb_sw, writes ignored.
  - 1 BTN_STATE: deb_btn, writes ignored.
  - 2 BTN_EDGE: sticky flags, write-1-to-clear.
  - 3 IRQ_EN: read/write, NUM_BTN bits.
  - 4 INFO: {8'h1, 8'h0, NUM_BTN[7:0], NUM_SW[7:0]}, read-only.
  - 5-7: read 0, writes ignored.
  - Bits above the field width read 0.
- Read timing: rd_en sampled at posedge N. rd_data/rd_valid are driven at posedge N+1 and held 1 cycle. Back-to-back reads are allowed, one per cycle. When rd_valid=0, rd_data=0.
- Read value is the register contents before any same-cycle write or edge set, i.e. the old value.
- W1C collision: if btn_rise sets a bit in the same cycle a write clears it, set wins and the bit stays 1.
- Simultaneous rd_en and wr_en to the same index: the read returns the old value and the write takes effect.
- irq is registered: it updates the cycle after BTN_EDGE or IRQ_EN changes.
- Button release (falling edge) sets nothing.
- Holding a button produces exactly one edge.

Test Plan:
- Reset then idle, DEBOUNCE_CYCLES=4 -> every register reads 0 except INFO=32'h0100_0410; irq=0; rd_valid pulses exactly once per rd_en, 1 cycle later.
- sw_raw=16'h00AA held stable -> SW_STATE reads 32'h0000_00AA within 10 cycles. A 3-cycle pulse on sw_raw[0] -> SW_STATE unchanged.
- btn_raw[2] pressed and held 40 cycles -> BTN_STATE=4, BTN_EDGE=4 set exactly once; release -> BTN_STATE=0, BTN_EDGE still 4; write 4 to index 2 -> reads 0.
- IRQ_EN=4'b0100, press btn[2] -> irq rises 1 cycle after BTN_EDGE[2]; W1C -> irq falls 1 cycle after. Press btn[0] with IRQ_EN[0]=0 -> irq stays 0.
- Force btn_rise[1] in the same cycle as a W1C write of 2 -> BTN_EDGE[1]=1. A same-cycle read of index 2 returns the pre-update value.
- Assert reset_n=0 for 1 cycle while rd_en is high and BTN_EDGE=4'hF -> rd_valid=0 next cycle, all registers 0, irq=0.
